// File: rtl/mul8_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-serial 8x8 multiply sequencer.
package mul8_seq_pkg;

    localparam int ACC_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STEP0 = 3'd1,
        STEP1 = 3'd2,
        STEP2 = 3'd3,
        STEP3 = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Partial-product alignment for aL*bL, aL*bH, aH*bL, aH*bH.
    localparam logic [3:0] STEP_SHIFT [4] = '{4'd0, 4'd4, 4'd4, 4'd8};

endpackage

// File: rtl/mul8_seq_ctrl_main_mul.sv
// Shared 4x4 -> 8 unsigned combinational multiplier array.
module main_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    assign p = {4'b0000, a} * {4'b0000, b};

endmodule

// File: rtl/mul8_seq_ctrl.sv
// 8x8 unsigned multiply (with optional accumulate) built from four passes
// through one shared 4x4 multiplier.
//
// state | meaning
// IDLE  | waiting for an operand pair
// STEP0 | aL*bL      added to work register
// STEP1 | aL*bH << 4 added to work register
// STEP2 | aH*bL << 4 added to work register
// STEP3 | aH*bH << 8 added, result committed to acc_q
// DONE  | result presented until the consumer takes it
module mul8_seq_ctrl
    import mul8_seq_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_acc,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_result,
    output logic             busy
);

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic [ACC_W-1:0] work_q;
    logic [ACC_W-1:0] acc_q;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       step_shift;
    logic [7:0]       prod;
    logic [ACC_W-1:0] partial;
    logic [ACC_W-1:0] work_next;
    logic             accept;

    main_mul u_main_mul (
        .a (nib_a),
        .b (nib_b),
        .p (prod)
    );

    // Gating with rst_n keeps in_ready low for the whole reset window.
    assign in_ready = rst_n && !clr &&
                      ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    assign busy       = (state_q == STEP0) || (state_q == STEP1) ||
                        (state_q == STEP2) || (state_q == STEP3);
    assign out_valid  = (state_q == DONE);
    assign out_result = acc_q;

    assign partial   = ACC_W'(prod) << step_shift;
    assign work_next = work_q + partial;

    always_comb begin
        state_d    = state_q;
        nib_a      = 4'd0;
        nib_b      = 4'd0;
        step_shift = 4'd0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = STEP0;
            end
            STEP0: begin
                nib_a      = a_q[3:0];
                nib_b      = b_q[3:0];
                step_shift = STEP_SHIFT[0];
                state_d    = STEP1;
            end
            STEP1: begin
                nib_a      = a_q[3:0];
                nib_b      = b_q[7:4];
                step_shift = STEP_SHIFT[1];
                state_d    = STEP2;
            end
            STEP2: begin
                nib_a      = a_q[7:4];
                nib_b      = b_q[3:0];
                step_shift = STEP_SHIFT[2];
                state_d    = STEP3;
            end
            STEP3: begin
                nib_a      = a_q[7:4];
                nib_b      = b_q[7:4];
                step_shift = STEP_SHIFT[3];
                state_d    = DONE;
            end
            DONE: begin
                if (out_ready) state_d = accept ? STEP0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clr) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            acc_q   <= '0;
        end else if (clr) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            // The accumulate base is folded into the work register at accept.
            if (accept) begin
                a_q    <= in_a;
                b_q    <= in_b;
                work_q <= in_acc ? acc_q : '0;
            end else if (busy) begin
                work_q <= work_next;
            end
            if (state_q == STEP3) acc_q <= work_next;
        end
    end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed self-checking bench for mul8_seq_ctrl with hand-computed results.
module tb_mul8_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_acc;
    logic        clr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        busy;

    int vectors;
    int miscompares;

    mul8_seq_ctrl #(.ACC_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_acc     (in_acc),
        .clr        (clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand pair for a single edge (caller guarantees in_ready).
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic acc);
        in_a     = a;
        in_b     = b;
        in_acc   = acc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Full op from IDLE: result captured in the first DONE cycle, then popped.
    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic acc,
                       output logic [15:0] res, output logic ov);
        issue(a, b, acc);
        repeat (4) tick();
        res       = out_result;
        ov        = out_valid;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_a = 8'h00; in_b = 8'h00;
        in_acc = 1'b0; clr = 1'b0; out_ready = 1'b1;
        #3;
        vectors++;
        if ({in_ready, out_valid, busy, out_result} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b busy=%b res=%h expected all 0",
                     in_ready, out_valid, busy, out_result);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_idle_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_ff_latency();
        issue(8'hFF, 8'hFF, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            vectors++;
            if (busy !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL ff_step_T+%0d: got busy=%b ov=%b expected busy=1 ov=0",
                         k, busy, out_valid);
            end
            tick();
        end
        vectors++;
        if (out_valid !== 1'b1 || busy !== 1'b0 || out_result !== 16'hFE01) begin
            miscompares++;
            $display("FAIL ff_done_T+5: got ov=%b busy=%b res=%h expected ov=1 busy=0 res=fe01",
                     out_valid, busy, out_result);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ff_pop_idle: got ov=%b rdy=%b expected ov=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_accumulate();
        logic [15:0] res;
        logic        ov;
        run(8'h12, 8'h34, 1'b0, res, ov);
        vectors++;
        if (res !== 16'h03A8 || ov !== 1'b1) begin
            miscompares++;
            $display("FAIL acc_first: got %h ov=%b expected 03a8 ov=1", res, ov);
        end
        run(8'h03, 8'h04, 1'b1, res, ov);
        vectors++;
        if (res !== 16'h03B4 || ov !== 1'b1) begin
            miscompares++;
            $display("FAIL acc_second: got %h ov=%b expected 03b4 ov=1", res, ov);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] res;
        logic        ov;
        run(8'hFF, 8'hFF, 1'b0, res, ov);
        vectors++;
        if (res !== 16'hFE01) begin
            miscompares++;
            $display("FAIL wrap_first: got %h expected fe01", res);
        end
        run(8'hFF, 8'hFF, 1'b1, res, ov);
        vectors++;
        if (res !== 16'hFC02) begin
            miscompares++;
            $display("FAIL wrap_second: got %h expected fc02", res);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] res;
        logic        ov;
        issue(8'hFF, 8'hFF, 1'b0);
        repeat (4) tick();
        in_a = 8'h05; in_b = 8'h06; in_acc = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_result !== 16'hFE01 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_cycle_%0d: got ov=%b res=%h rdy=%b expected ov=1 res=fe01 rdy=0",
                         k, out_valid, out_result, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_restart: got ov=%b busy=%b expected ov=0 busy=1", out_valid, busy);
        end
        repeat (3) tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_early: got ov=%b expected 0", out_valid);
        end
        tick();
        res = out_result;
        ov  = out_valid;
        vectors++;
        if (ov !== 1'b1 || res !== 16'h001E) begin
            miscompares++;
            $display("FAIL b2b_result: got ov=%b res=%h expected ov=1 res=001e", ov, res);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_clr();
        logic [15:0] res;
        logic        ov;
        logic        seen_valid;
        run(8'h10, 8'h10, 1'b0, res, ov);
        issue(8'h77, 8'h22, 1'b1);
        repeat (2) tick();
        clr = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_blocks_ready: got %b expected 0", in_ready);
        end
        tick();
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_result !== 16'h0000) begin
            miscompares++;
            $display("FAIL clr_idle: got busy=%b ov=%b res=%h expected 0 0 0000",
                     busy, out_valid, out_result);
        end
        seen_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) seen_valid = 1'b1;
            tick();
        end
        vectors++;
        if (seen_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_no_valid: got out_valid seen=%b expected 0", seen_valid);
        end
        run(8'h02, 8'h03, 1'b1, res, ov);
        vectors++;
        if (res !== 16'h0006) begin
            miscompares++;
            $display("FAIL clr_then_acc: got %h expected 0006", res);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] res;
        logic        ov;
        run(8'h10, 8'h10, 1'b0, res, ov);
        vectors++;
        if (res !== 16'h0100) begin
            miscompares++;
            $display("FAIL pre_reset_result: got %h expected 0100", res);
        end
        issue(8'h55, 8'h66, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, busy, out_result} !== 19'd0) begin
            miscompares++;
            $display("FAIL async_reset: got rdy=%b ov=%b busy=%b res=%h expected all 0",
                     in_ready, out_valid, busy, out_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run(8'h0A, 8'h0B, 1'b1, res, ov);
        vectors++;
        if (res !== 16'h006E || ov !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_op: got %h ov=%b expected 006e ov=1", res, ov);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_ff_latency();
        test_accumulate();
        test_wrap();
        test_back_to_back();
        test_clr();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
